ex_muldiv_unit: RTL and testbench

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/ex_muldiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative EX-stage multiply/divide unit.
// Works one bit per clock on unsigned magnitudes. Shift-add handles multiply
// and restoring division handles divide. A single FIX cycle then applies the
// sign correction and computes the condition codes. The pipeline is stalled
// from the accepting cycle until DONE, so the result is captured while stall is low.
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             R,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] y_out,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             C,
    output logic             div_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   mcand;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               ovf;

    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               div_by_zero;
    logic               sdiv_ovf;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_res;
    logic [WIDTH-1:0]   fix_y;

    // Operand decode, per-bit datapath step and final sign correction
    always_comb begin
        sign_a      = op[0] & a[WIDTH-1];
        sign_b      = op[0] & b[WIDTH-1];
        mag_a       = sign_a ? -a : a;
        mag_b       = sign_b ? -b : b;
        div_by_zero = op[1] & (b == '0);
        sdiv_ovf    = (op == 2'b11) & (a == MOST_NEG) & (b == '1);

        addend      = lo[0] ? mcand : '0;
        mul_sum     = {1'b0, hi} + {1'b0, addend};

        div_trial   = {hi, lo[WIDTH-1]};
        div_ge      = div_trial >= {1'b0, mcand};
        div_rem     = div_trial[WIDTH-1:0] - mcand;

        prod        = {hi, lo};
        prod_fix    = neg_lo ? -prod : prod;
        quot_fix    = neg_lo ? -lo : lo;
        rem_fix     = neg_hi ? -hi : hi;
        fix_res     = is_div ? quot_fix : prod_fix[WIDTH-1:0];
        fix_y       = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    end

    // Control FSM plus the shared hi/lo shift registers used by both algorithms
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state  <= S_IDLE;
            count  <= '0;
            hi     <= '0;
            lo     <= '0;
            mcand  <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            ovf    <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (div_by_zero) begin
                            state <= S_DONE;
                        end else begin
                            state  <= S_CALC;
                            count  <= '0;
                            hi     <= '0;
                            lo     <= mag_a;
                            mcand  <= mag_b;
                            is_div <= op[1];
                            neg_lo <= sign_a ^ sign_b;
                            neg_hi <= op[1] & sign_a;
                            ovf    <= sdiv_ovf;
                        end
                    end
                end
                S_CALC: begin
                    if (is_div) begin
                        hi <= div_ge ? div_rem : div_trial[WIDTH-1:0];
                        lo <= {lo[WIDTH-2:0], div_ge};
                    end else begin
                        {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Architectural outputs change only on the edge that enters DONE
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            result   <= '0;
            y_out    <= '0;
            Z        <= 1'b0;
            N        <= 1'b0;
            V        <= 1'b0;
            C        <= 1'b0;
            div_zero <= 1'b0;
        end else if (!flush) begin
            if (state == S_IDLE && start && div_by_zero) begin
                result   <= '1;
                y_out    <= a;
                Z        <= 1'b0;
                N        <= 1'b1;
                V        <= 1'b0;
                C        <= 1'b0;
                div_zero <= 1'b1;
            end else if (state == S_FIX) begin
                result   <= fix_res;
                y_out    <= fix_y;
                Z        <= (fix_res == '0);
                N        <= fix_res[WIDTH-1];
                V        <= ovf;
                C        <= 1'b0;
                div_zero <= 1'b0;
            end
        end
    end

    // Handshake outputs; stall is held low throughout reset
    always_comb begin
        busy  = (state == S_CALC) | (state == S_FIX);
        done  = (state == S_DONE);
        stall = (start & (state == S_IDLE) & ~R) | busy;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: scoreboard bench for ex_muldiv_unit (WIDTH=32).
// Stimulus pushes hand-computed responses; a monitor pops on every done pulse.
module tb_ex_muldiv_unit;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] y;
        logic [4:0]   flags;
    } exp_t;

    logic         clk;
    logic         R;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] y_out;
    logic         Z;
    logic         N;
    logic         V;
    logic         C;
    logic         div_zero;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .R(R), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .result(result), .y_out(y_out),
        .Z(Z), .N(N), .V(V), .C(C), .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Issue one operation, queue its expected response and check timing/stall
    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic [W-1:0] er, input logic [W-1:0] ey, input logic [4:0] ef,
                                 input int lat);
        int n;
        logic stall_bad;
        exp_t e;
        @(negedge clk);
        op = o; a = aa; b = bb; start = 1'b1;
        e.res = er; e.y = ey; e.flags = ef;
        sb.push_back(e);
        #1 checkOutput("stall_on_start", {63'b0, stall}, 64'd1);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        stall_bad = 1'b0;
        while (done !== 1'b1 && n < 80) begin
            if (stall !== 1'b1) stall_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        checkOutput("latency", 64'(n), 64'(lat));
        checkOutput("stall_while_busy", {63'b0, stall_bad}, 64'd0);
        checkOutput("stall_in_done", {63'b0, stall}, 64'd0);
        @(negedge clk);
        checkOutput("done_one_cycle", {62'b0, done, busy}, 64'd0);
    endtask

    // Monitor: every done pulse is matched against the oldest queued response
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_done", {63'b0, done}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("result", {32'b0, result}, {32'b0, e.res});
                checkOutput("y_out", {32'b0, y_out}, {32'b0, e.y});
                checkOutput("flags_ZNVC_dz", {59'b0, Z, N, V, C, div_zero}, {59'b0, e.flags});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        R = 1'b1; start = 1'b1; op = 2'b00; a = '0; b = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_ctrl", {56'b0, busy, stall, done, div_zero, Z, N, V, C}, 64'd0);
        checkOutput("reset_result", {32'b0, result}, 64'd0);
        checkOutput("reset_y_out", {32'b0, y_out}, 64'd0);
        @(negedge clk);
        start = 1'b0; R = 1'b0;

        // flags are {Z,N,V,C,div_zero}
        applyStimulus(2'b00, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'h00000001, 5'b01000, LAT);
        applyStimulus(2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32'hFFFFFFFF, 5'b01000, LAT);
        applyStimulus(2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 5'b01000, LAT);
        applyStimulus(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 5'b01100, LAT);
        applyStimulus(2'b10, 32'd5,        32'd0,        32'hFFFFFFFF, 32'h00000005, 5'b01001, 1);
        applyStimulus(2'b10, 32'd100,      32'd7,        32'h0000000E, 32'h00000002, 5'b00000, LAT);
        applyStimulus(2'b00, 32'd0,        32'd12345,    32'h00000000, 32'h00000000, 5'b10000, LAT);
        applyStimulus(2'b11, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 5'b01000, LAT);
        applyStimulus(2'b01, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 5'b10000, LAT);
        applyStimulus(2'b10, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'h00000000, 5'b01000, LAT);
        applyStimulus(2'b11, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF8, 5'b01001, 1);

        // start held high through DONE: one done only, no re-acceptance in DONE
        @(negedge clk);
        op = 2'b10; a = 32'd1000; b = 32'd10; start = 1'b1;
        sb.push_back('{res: 32'd100, y: 32'd0, flags: 5'b00000});
        n = 0;
        while (done !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        checkOutput("held_latency", 64'(n), 64'(LAT));
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("held_no_reaccept", {62'b0, busy, done}, 64'd0);
        end

        // flush at CALC count 10
        @(negedge clk);
        op = 2'b00; a = 32'd77; b = 32'd99; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 11) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busy_before_flush", {63'b0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_idle", {62'b0, busy, done}, 64'd0);
        checkOutput("flush_result_kept", {32'b0, result}, 64'd100);
        repeat (W + 4) @(negedge clk);
        applyStimulus(2'b00, 32'd3, 32'd4, 32'd12, 32'd0, 5'b00000, LAT);

        // reset at CALC count 20
        @(negedge clk);
        op = 2'b00; a = 32'd77; b = 32'd99; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 21) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busy_before_reset", {63'b0, busy}, 64'd1);
        R = 1'b1;
        #1;
        checkOutput("reset_abort_ctrl", {61'b0, busy, stall, done}, 64'd0);
        checkOutput("reset_abort_result", {32'b0, result}, 64'd0);
        @(negedge clk);
        R = 1'b0;
        repeat (W + 4) @(negedge clk);
        applyStimulus(2'b00, 32'd3, 32'd4, 32'd12, 32'd0, 5'b00000, LAT);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
